// File: rtl/led_sequencer.sv
// led_sequencer: table-driven LED blink pattern player on a prescaled tick
module led_sequencer #(
  parameter int DEPTH    = 8,
  parameter int DUR_W    = 16,
  parameter int PRESCALE = 12000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic                     wr_level,
  input  logic [DUR_W-1:0]         wr_dur,
  input  logic                     wr_last,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     loop,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH)-1:0] step_idx,
  output logic                     out
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_n;
  logic [DEPTH-1:0] level, last;
  logic [DUR_W-1:0] dur [DEPTH];
  logic [PW-1:0] pre_cnt, pre_n;
  logic [DUR_W-1:0] dur_cnt, dur_n, dur_max;
  logic [AW-1:0] idx_n, idx_inc;
  logic out_n, busy_n, done_n, tick, step_end, at_end;
  assign tick = pre_cnt == PW'(PRESCALE - 1);
  assign dur_max = dur[step_idx] == '0 ? '0 : dur[step_idx] - DUR_W'(1);
  assign step_end = tick && dur_cnt == dur_max;
  assign at_end = last[step_idx] || step_idx == AW'(DEPTH - 1);
  assign idx_inc = step_idx + AW'(1);
  always_comb begin
    state_n = state;
    out_n = 1'b0;
    busy_n = 1'b0;
    done_n = 1'b0;
    idx_n = '0;
    pre_n = '0;
    dur_n = '0;
    if (state == IDLE) begin
      if (start && !stop) begin
        state_n = RUN;
        busy_n = 1'b1;
        out_n = level[0];
      end
    end else if (stop) begin
      state_n = IDLE;
    end else begin
      busy_n = 1'b1;
      pre_n = tick ? '0 : pre_cnt + PW'(1);
      dur_n = step_end ? '0 : dur_cnt + DUR_W'(tick);
      idx_n = step_idx;
      out_n = out;
      if (step_end && !at_end) begin
        idx_n = idx_inc;
        out_n = level[idx_inc];
      end else if (step_end && loop) begin
        idx_n = '0;
        out_n = level[0];
      end else if (step_end) begin
        state_n = IDLE;
        busy_n = 1'b0;
        done_n = 1'b1;
        idx_n = '0;
        out_n = 1'b0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      out <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      step_idx <= '0;
      pre_cnt <= '0;
      dur_cnt <= '0;
      level <= '0;
      last <= '0;
      for (int i = 0; i < DEPTH; i++) dur[i] <= '0;
    end else begin
      state <= state_n;
      out <= out_n;
      busy <= busy_n;
      done <= done_n;
      step_idx <= idx_n;
      pre_cnt <= pre_n;
      dur_cnt <= dur_n;
      if (wr_en && state == IDLE) begin
        level[wr_addr] <= wr_level;
        dur[wr_addr] <= wr_dur;
        last[wr_addr] <= wr_last;
      end
    end
  end
endmodule

// File: doc/led_sequencer.md
# led_sequencer

Programmable blink-pattern controller that drives the board LED output `out`. It holds a small table of (level, duration) steps and plays them in order on a prescaled time base, once or looping. A host-side block loads the table and issues start/stop. The sequencer replaces a free-running LED divider so patterns can change without resynthesis.

## Interface

- `DEPTH`, 8: number of step entries; power of two, at least 2.
- `DUR_W`, 16: width of the per-step duration, counted in ticks.
- `PRESCALE`, 12000: clock cycles per tick; at least 1.
- `clk` input 1: single clock; all logic on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `wr_en` input 1: table write strobe.
- `wr_addr` input log2(DEPTH): entry to write.
- `wr_level` input 1: LED level for the entry.
- `wr_dur` input DUR_W: entry duration in ticks; 0 is treated as 1.
- `wr_last` input 1: entry ends the pattern.
- `start` input 1: begin playback at entry 0.
- `stop` input 1: abort playback.
- `loop` input 1: repeat the pattern after the last step.
- `busy` output 1: playback in progress.
- `done` output 1: one-cycle pulse when a non-looping pattern completes.
- `step_idx` output log2(DEPTH): index of the entry currently playing.
- `out` output 1: LED drive.

## Operation

- Reset clears the whole table (level 0, dur 0, last 0) and sets the state to IDLE.
- Output reset values: `out`=0, `busy`=0, `done`=0, `step_idx`=0.
- All outputs are registered. The prescaler and duration counters reset to 0.
- The FSM has two states, IDLE and RUN.
- IDLE:
  - `out`=0 and `busy`=0.
  - A write with `wr_en`=1 updates entry `wr_addr` on that edge.
  - `start`=1 with `stop`=0 moves to RUN: `step_idx`=0, `out`=level[0], both counters cleared.
  - If `start` and `stop` are both 1, `stop` wins and the block stays in IDLE.
- RUN:
  - `busy`=1. Writes are ignored. `start` is ignored.
  - The prescaler counts 0..PRESCALE-1; a tick occurs on the cycle it equals PRESCALE-1, then it wraps to 0.
  - On each tick the duration counter increments.
  - A step ends on the tick where dur_cnt equals max(dur,1)-1. The duration counter is then cleared.
- Step advance, when entry i ends:
  - If last[i]=0 and i<DEPTH-1: `step_idx`=i+1 and `out`=level[i+1].
  - If last[i]=1 or i=DEPTH-1 (implicit last), and `loop`=1 (sampled on that edge): `step_idx`=0 and `out`=level[0]. No `done` pulse.
  - If last[i]=1 or i=DEPTH-1, and `loop`=0: go to IDLE with `out`=0, `busy`=0, `step_idx`=0, and `done`=1 for one cycle.
- `stop`=1 in RUN: the next edge enters IDLE with `out`=0, `busy`=0, `step_idx`=0. No `done` pulse. `stop` overrides a simultaneous step end.
- `rst` overrides everything in every state.
- Width rules:
  - dur_cnt is DUR_W bits and never wraps, because a step ends at max(dur,1)-1.
  - The prescaler is clog2(PRESCALE) bits, minimum 1.

## Timing

- `start` sampled at edge k: after edge k, `busy`=1 and `out`=level[0].
- Step i lasts exactly max(dur_i,1)*PRESCALE cycles. This covers the first step, every later step, and every step after a loop wrap; there are no gap cycles.
- The edge ending the final step drives `out`=0, `busy`=0 and `done`=1 together. After the following edge, `done`=0.
- A new `start` is accepted on the cycle `done` is high, since the block is already in IDLE. The new pattern begins one cycle later.
- Stop latency is one edge.
- The earliest new `start` after a stop is sampled on the edge after the stop took effect.
- A table write at edge j is visible to a `start` sampled at edge j+1.

## Test plan

All scenarios use PRESCALE=4.

- Reset: set `rst`=1 for 2 cycles while `start`=1.
  - Required: `out`=0, `busy`=0, `done`=0, `step_idx`=0. After release, playback stays idle with no write.
- Single-shot: load entry 0 = (1,3,0) and entry 1 = (0,2,1); pulse `start` with `loop`=0.
  - Required: `out`=1 for 12 cycles, then `out`=0 with `step_idx`=1 for 8 cycles.
  - Then `done`=1 for exactly 1 cycle, coincident with `busy` falling.
- Loop and zero duration: load entry 0 = (1,0,0) and entry 1 = (0,1,1); `loop`=1.
  - Required: `out` alternates 1 for 4 cycles and 0 for 4 cycles for at least 3 periods. No `done` pulse.
  - Deassert `loop`: the pattern ends at the next completion of entry 1 with one `done` pulse.
- Stop mid-step: in the single-shot pattern, assert `stop` 5 cycles into entry 0.
  - Required: the next cycle has `out`=0 and `busy`=0, and no `done` pulse.
  - A restart then runs entry 0 for a full 12 cycles.
- Implicit last and write lockout:
  - Fill all 8 entries as (i%2,1,0) with no last bit; run with `loop`=0.
    - Required: 32 cycles of alternating 4-cycle levels, then `done`.
  - During the run, write entry 3 = (1,9,1).
    - Required: the write is ignored, so the timing is unchanged.
- Simultaneous events:
  - `start` and `stop` in the same cycle in IDLE. Required: the block stays idle.
  - `stop` on the same edge a step ends. Required: the block goes to IDLE with no advance and no `done` pulse.
